eql_cmp_seq: RTL and testbench

EQL_CMP_SEQ -- requirements
Module: eql_cmp_seq

---
 rtl/eql_cmp_seq.sv | 108 ++++++++++
 tb/tb_eql_cmp_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/eql_cmp_seq.sv
// Sequential equality comparator: counts consecutive matches of a sampled word
// against a loadable reference and raises a sustained-match request until acknowledged.
module eql_cmp_seq #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] data_in,
  input  logic          data_vld,
  input  logic          ref_load,
  input  logic [DW-1:0] ref_in,
  input  logic [CW-1:0] thresh,
  input  logic          ackout,
  output logic          eql,
  output logic          cont_eql,
  output logic [CW-1:0] match_cnt,
  output logic          locked
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MATCH = 2'd1;
  localparam logic [1:0] LOCK  = 2'd2;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [DW-1:0] ref_r;
  logic          eql_n;
  logic          cont_eql_n;
  logic [CW-1:0] match_cnt_n;
  logic          locked_n;
  logic          hit_c;
  logic [CW-1:0] inc_c;

  // Compare against the reference held before any same-cycle load.
  assign hit_c = (data_in == ref_r);
  // match_cnt is zero in IDLE, so the same saturating increment serves both states.
  assign inc_c = (match_cnt == CNT_MAX) ? match_cnt : match_cnt + CW'(1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      ref_r     <= '0;
      eql       <= 1'b0;
      cont_eql  <= 1'b0;
      match_cnt <= '0;
      locked    <= 1'b0;
    end else begin
      state     <= state_n;
      eql       <= eql_n;
      cont_eql  <= cont_eql_n;
      match_cnt <= match_cnt_n;
      locked    <= locked_n;
      if (ref_load) begin
        ref_r <= ref_in;
      end
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n     = state;
    eql_n       = eql;
    cont_eql_n  = cont_eql;
    match_cnt_n = match_cnt;
    locked_n    = locked;
    case (state)
      IDLE, MATCH: begin
        if (data_vld) begin
          if (hit_c) begin
            eql_n       = 1'b1;
            match_cnt_n = inc_c;
            if ((thresh != '0) && (inc_c >= thresh)) begin
              state_n    = LOCK;
              cont_eql_n = 1'b1;
              locked_n   = 1'b1;
            end else begin
              state_n = MATCH;
            end
          end else begin
            state_n     = IDLE;
            eql_n       = 1'b0;
            match_cnt_n = '0;
          end
        end
      end
      LOCK: begin
        if (ackout) begin
          state_n     = IDLE;
          eql_n       = 1'b0;
          cont_eql_n  = 1'b0;
          match_cnt_n = '0;
          locked_n    = 1'b0;
        end
      end
      default: begin
        state_n     = IDLE;
        eql_n       = 1'b0;
        cont_eql_n  = 1'b0;
        match_cnt_n = '0;
        locked_n    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_eql_cmp_seq.sv
// Directed bench for eql_cmp_seq: expected output vectors are queued per driven
// cycle and checked against the registered outputs just after the clock edge.
module tb_eql_cmp_seq;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  typedef struct {
    string          tag;
    logic [CW+2:0]  vec;   // {eql, cont_eql, match_cnt, locked}
  } exp_t;

  logic          clock;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          data_vld;
  logic          ref_load;
  logic [DW-1:0] ref_in;
  logic [CW-1:0] thresh;
  logic          ackout;
  logic          eql;
  logic          cont_eql;
  logic [CW-1:0] match_cnt;
  logic          locked;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  eql_cmp_seq #(.DW(DW), .CW(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .data_vld  (data_vld),
    .ref_load  (ref_load),
    .ref_in    (ref_in),
    .thresh    (thresh),
    .ackout    (ackout),
    .eql       (eql),
    .cont_eql  (cont_eql),
    .match_cnt (match_cnt),
    .locked    (locked)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Queue the expectation for the current inputs, clock once, then check.
  task automatic step(input string tag, input logic e, input logic c,
                      input logic [CW-1:0] n, input logic l);
    exp_t x;
    exp_t got;
    logic [CW+2:0] obs;
    x.tag = tag;
    x.vec = {e, c, n, l};
    exp_q.push_back(x);
    @(posedge clock);
    #1;
    got = exp_q.pop_front();
    obs = {eql, cont_eql, match_cnt, locked};
    checks++;
    assert (obs === got.vec) else begin
      failures++;
      $error("FAIL %s observed eql/cont/cnt/locked=%b/%b/%0d/%b expected %b/%b/%0d/%b",
             got.tag, obs[CW+2], obs[CW+1], obs[CW:1], obs[0],
             got.vec[CW+2], got.vec[CW+1], got.vec[CW:1], got.vec[0]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    data_in  = '0;
    data_vld = 1'b0;
    ref_load = 1'b0;
    ref_in   = '0;
    thresh   = '0;
    ackout   = 1'b1;

    // Reset dominates even with ackout and data asserted.
    data_vld = 1'b1;
    data_in  = 8'h00;
    step("reset0", 0, 0, 0, 0);
    step("reset1", 0, 0, 0, 0);
    data_vld = 1'b0;
    ackout   = 1'b0;

    // Load reference and threshold.
    reset    = 1'b1;
    ref_load = 1'b1;
    ref_in   = 8'hA5;
    thresh   = 4'd3;
    step("load_ref", 0, 0, 0, 0);
    ref_load = 1'b0;

    // Three matches reach thresh=3 and lock.
    data_vld = 1'b1;
    data_in  = 8'hA5;
    step("match1", 1, 0, 1, 0);
    step("match2", 1, 0, 2, 0);
    step("match3_lock", 1, 1, 3, 1);

    // LOCK ignores data, then ackout releases.
    data_in = 8'h00;
    for (int i = 0; i < 5; i++) step("lock_hold", 1, 1, 3, 1);
    data_vld = 1'b0;
    ackout   = 1'b1;
    step("ack_release", 0, 0, 0, 0);
    step("ack_in_idle", 0, 0, 0, 0);
    ackout = 1'b0;

    // Mismatch resets the run; no lock below thresh=4.
    thresh   = 4'd4;
    data_vld = 1'b1;
    data_in  = 8'hA5; step("t4_a5_1", 1, 0, 1, 0);
    data_in  = 8'hA5; step("t4_a5_2", 1, 0, 2, 0);
    data_in  = 8'h3C; step("t4_3c",   0, 0, 0, 0);
    data_in  = 8'hA5; step("t4_a5_3", 1, 0, 1, 0);
    data_vld = 1'b0;  step("t4_hold", 1, 0, 1, 0);
    data_vld = 1'b1;
    data_in  = 8'h3C; step("t4_miss", 0, 0, 0, 0);

    // thresh=0: count saturates, never locks.
    thresh  = 4'd0;
    data_in = 8'hA5;
    for (int i = 1; i <= 20; i++) begin
      step("sat", 1, 0, (i > 15) ? 4'd15 : CW'(i), 0);
    end
    data_in = 8'h3C;
    step("sat_miss", 0, 0, 0, 0);

    // Same-cycle load compares with the old reference.
    ref_load = 1'b1;
    ref_in   = 8'h3C;
    data_in  = 8'h3C;
    step("ref_old", 0, 0, 0, 0);
    ref_load = 1'b0;
    step("ref_new", 1, 0, 1, 0);

    // thresh=1 from IDLE locks on the first match.
    thresh  = 4'd1;
    data_in = 8'hA5;
    step("t1_miss", 0, 0, 0, 0);
    data_in = 8'h3C;
    step("t1_direct_lock", 1, 1, 1, 1);

    // Reset mid-LOCK clears everything including the reference.
    reset    = 1'b0;
    data_vld = 1'b0;
    step("reset_in_lock", 0, 0, 0, 0);
    reset    = 1'b1;
    data_vld = 1'b1;
    data_in  = 8'h00;
    step("ref_cleared", 1, 1, 1, 1);
    data_vld = 1'b0;
    ackout   = 1'b1;
    step("ack2", 0, 0, 0, 0);
    ackout = 1'b0;

    // Lowering thresh below the current count locks on the next match.
    thresh   = 4'd5;
    data_vld = 1'b1;
    data_in  = 8'h00;
    step("tc_1", 1, 0, 1, 0);
    step("tc_2", 1, 0, 2, 0);
    step("tc_3", 1, 0, 3, 0);
    thresh   = 4'd2;
    data_vld = 1'b0;
    step("tc_idle_wait", 1, 0, 3, 0);
    data_vld = 1'b1;
    step("tc_lock", 1, 1, 4, 1);
    data_vld = 1'b0;
    ackout   = 1'b1;
    step("ack3", 0, 0, 0, 0);
    ackout = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
